// File: rtl/matmul_engine.sv
// NxN unsigned matrix multiply: loads W then X (row-major), one MAC per cycle, streams R row-major.
// Latency: 2*N*N load beats, N*N*N compute cycles, N*N unload beats; in/out use valid-ready handshakes.
// Optional macro MATMUL_SAT_EN clamps results to 2^OW-1; otherwise results wrap modulo 2^OW.
module matmul_engine #(
    parameter int N  = 3,
    parameter int DW = 4,
    parameter int OW = 10
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          start,
    input  logic          clear,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [DW-1:0] in_data,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [OW-1:0] out_data,
    output logic          busy,
    output logic          done
);
    localparam int NN  = N * N;
    localparam int FW  = 2 * DW + $clog2(N);
    localparam int MW  = (FW > OW) ? FW : OW;
    localparam int IW  = $clog2(NN);
    localparam int KW  = $clog2(N);
    localparam int LCW = $clog2(2 * NN);
    localparam logic [KW-1:0]  KLAST = KW'(N - 1);
    localparam logic [IW-1:0]  ULAST = IW'(NN - 1);
    localparam logic [LCW-1:0] LLAST = LCW'(2 * NN - 1);

    typedef enum logic [1:0] {S_IDLE, S_LOAD, S_COMPUTE, S_UNLOAD} state_t;
    state_t state;

    logic [DW-1:0]  w_buf [NN];
    logic [DW-1:0]  x_buf [NN];
    logic [OW-1:0]  r_buf [NN];
    logic [LCW-1:0] load_cnt;
    logic [KW-1:0]  ci, cj, ck;
    logic [IW-1:0]  u_idx;
    logic [FW-1:0]  acc, acc_next;
    logic [2*DW-1:0] prod;
    logic [IW-1:0]  w_idx, x_idx, r_idx;
    logic [OW-1:0]  red;

    assign busy     = (state != S_IDLE);
    assign in_ready = (state == S_LOAD);

    always_comb begin
        w_idx    = IW'(ci * N + ck);
        x_idx    = IW'(ck * N + cj);
        r_idx    = IW'(ci * N + cj);
        prod     = w_buf[w_idx] * x_buf[x_idx];
        acc_next = ((ck == '0) ? '0 : acc) + FW'(prod);
`ifdef MATMUL_SAT_EN
        if (MW'(acc_next) > MW'({OW{1'b1}}))
            red = {OW{1'b1}};
        else
            red = OW'(acc_next);
`else
        red = OW'(acc_next);
`endif
    end

    // Buffers are fully rewritten by every job, so they need no reset.
    always_ff @(posedge clk) begin
        if (state == S_LOAD && in_valid) begin
            if (load_cnt < LCW'(NN))
                w_buf[IW'(load_cnt)] <= in_data;
            else
                x_buf[IW'(load_cnt - LCW'(NN))] <= in_data;
        end
        if (state == S_COMPUTE && ck == KLAST)
            r_buf[r_idx] <= red;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= S_IDLE;
            load_cnt  <= '0;
            ci        <= '0;
            cj        <= '0;
            ck        <= '0;
            u_idx     <= '0;
            acc       <= '0;
            out_valid <= 1'b0;
            out_data  <= '0;
            done      <= 1'b0;
        end else begin
            done <= 1'b0;
            if (clear) begin
                state     <= S_IDLE;
                load_cnt  <= '0;
                ci        <= '0;
                cj        <= '0;
                ck        <= '0;
                u_idx     <= '0;
                acc       <= '0;
                out_valid <= 1'b0;
                out_data  <= '0;
            end else begin
                case (state)
                    S_IDLE: begin
                        if (start) begin
                            state    <= S_LOAD;
                            load_cnt <= '0;
                        end
                    end
                    S_LOAD: begin
                        if (in_valid) begin
                            if (load_cnt == LLAST) begin
                                state    <= S_COMPUTE;
                                load_cnt <= '0;
                                ci       <= '0;
                                cj       <= '0;
                                ck       <= '0;
                            end else begin
                                load_cnt <= load_cnt + 1'b1;
                            end
                        end
                    end
                    S_COMPUTE: begin
                        acc <= acc_next;
                        if (ck == KLAST) begin
                            ck <= '0;
                            if (cj == KLAST) begin
                                cj <= '0;
                                if (ci == KLAST) begin
                                    // r_buf[0] was written long ago; only the last element lands this cycle.
                                    ci        <= '0;
                                    state     <= S_UNLOAD;
                                    out_valid <= 1'b1;
                                    out_data  <= r_buf[0];
                                    u_idx     <= '0;
                                end else begin
                                    ci <= ci + 1'b1;
                                end
                            end else begin
                                cj <= cj + 1'b1;
                            end
                        end else begin
                            ck <= ck + 1'b1;
                        end
                    end
                    S_UNLOAD: begin
                        if (out_ready) begin
                            if (u_idx == ULAST) begin
                                state     <= S_IDLE;
                                out_valid <= 1'b0;
                                out_data  <= '0;
                                u_idx     <= '0;
                                done      <= 1'b1;
                            end else begin
                                u_idx    <= u_idx + 1'b1;
                                out_data <= r_buf[u_idx + 1'b1];
                            end
                        end
                    end
                    default: state <= S_IDLE;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_matmul_engine.sv
// Scoreboard bench for matmul_engine: default instance plus an OW=8 instance sharing the same stimulus.
module tb_matmul_engine;
    localparam int N  = 3;
    localparam int DW = 4;
    localparam int OW = 10;
    localparam int NN = N * N;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          start = 1'b0;
    logic          clear = 1'b0;
    logic          in_valid = 1'b0;
    logic [DW-1:0] in_data = '0;
    logic          out_ready = 1'b0;
    logic          in_ready, out_valid, busy, done;
    logic [OW-1:0] out_data;
    logic          in_ready8, out_valid8, busy8, done8;
    logic [7:0]    out_data8;

    matmul_engine #(.N(N), .DW(DW), .OW(OW)) u_dut (
        .clk(clk), .rst_n(rst_n), .start(start), .clear(clear),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .busy(busy), .done(done)
    );

    matmul_engine #(.N(N), .DW(DW), .OW(8)) u_dut8 (
        .clk(clk), .rst_n(rst_n), .start(start), .clear(clear),
        .in_valid(in_valid), .in_ready(in_ready8), .in_data(in_data),
        .out_valid(out_valid8), .out_ready(out_ready), .out_data(out_data8),
        .busy(busy8), .done(done8)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;
    int exp_q[$];
    int exp8_q[$];
    int w_m[NN];
    int x_m[NN];

    task automatic check(input string tag, input int obs, input int exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic int reduce(input int s, input int ow);
        int mx;
        mx = (1 << ow) - 1;
`ifdef MATMUL_SAT_EN
        return (s > mx) ? mx : s;
`else
        return s & mx;
`endif
    endfunction

    task automatic push_expected();
        for (int i = 0; i < N; i++) begin
            for (int j = 0; j < N; j++) begin
                int s;
                s = 0;
                for (int k = 0; k < N; k++)
                    s += w_m[i*N+k] * x_m[k*N+j];
                exp_q.push_back(reduce(s, OW));
                exp8_q.push_back(reduce(s, 8));
            end
        end
    endtask

    task automatic do_start();
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check("busy_after_start", busy, 1);
        check("in_ready_load", in_ready, 1);
        check("in_ready8_load", in_ready8, 1);
    endtask

    task automatic load(input int nbeats);
        for (int b = 0; b < nbeats; b++) begin
            int g;
            g = 0;
            in_valid = 1'b1;
            in_data  = (b < NN) ? DW'(w_m[b]) : DW'(x_m[b-NN]);
            while (!in_ready && g < 100) begin
                g++;
                @(negedge clk);
            end
            if (g >= 100) check("load_timeout", 0, 1);
            @(negedge clk);
        end
        in_valid = 1'b0;
    endtask

    task automatic run_job(input bit stall, input bit poke_start);
        int cnt, hs, g, p, held, e, e8;
        bit held_vld;
        push_expected();
        do_start();
        load(2 * NN);
        cnt = 0;
        while (!out_valid && cnt < 200) begin
            start = (poke_start && cnt == 3);
            if (cnt == 5) check("in_ready_compute", in_ready, 0);
            cnt++;
            @(negedge clk);
        end
        start = 1'b0;
        check("compute_cycles", cnt, N * N * N);
        hs = 0; g = 0; p = 0; held = 0; held_vld = 1'b0;
        while (hs < NN && g < 500) begin
            out_ready = stall ? ((p % 4 == 0) || (p % 4 == 3)) : 1'b1;
            p++;
            if (out_valid) begin
                check("done_early", done, 0);
                if (held_vld) check("hold_data", out_data, held);
                if (out_ready) begin
                    e  = exp_q.pop_front();
                    e8 = exp8_q.pop_front();
                    check("out_data", out_data, e);
                    check("out_data8", out_data8, e8);
                    hs++;
                    held_vld = 1'b0;
                end else begin
                    held_vld = 1'b1;
                    held = out_data;
                end
            end
            g++;
            @(negedge clk);
        end
        if (g >= 500) check("unload_timeout", 0, 1);
        check("done_pulse", done, 1);
        check("done8_pulse", done8, 1);
        check("busy_idle", busy, 0);
        check("busy8_idle", busy8, 0);
        check("out_valid_idle", out_valid, 0);
        check("out_valid8_idle", out_valid8, 0);
        out_ready = 1'b0;
        @(negedge clk);
        check("done_once", done, 0);
    endtask

    task automatic randomize_operands();
        for (int i = 0; i < NN; i++) begin
            w_m[i] = int'($urandom_range(0, 15));
            x_m[i] = int'($urandom_range(0, 15));
        end
    endtask

    initial begin
        repeat (2) @(negedge clk);
        check("rst_in_ready", in_ready, 0);
        check("rst_out_valid", out_valid, 0);
        check("rst_out_data", out_data, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        rst_n = 1'b1;
        @(negedge clk);

        // identity W times 1..9
        for (int i = 0; i < NN; i++) begin
            w_m[i] = (i % 4 == 0) ? 1 : 0;
            x_m[i] = i + 1;
        end
        run_job(1'b0, 1'b0);

        // saturating operands, start poked during compute
        for (int i = 0; i < NN; i++) begin
            w_m[i] = 15;
            x_m[i] = 15;
        end
        run_job(1'b0, 1'b1);

        randomize_operands();
        run_job(1'b1, 1'b0);

        // clear after 5 load beats
        do_start();
        load(5);
        clear = 1'b1;
        in_valid = 1'b1;
        @(negedge clk);
        clear = 1'b0;
        check("clear_busy", busy, 0);
        check("clear_in_ready", in_ready, 0);
        check("clear_out_valid", out_valid, 0);
        check("clear_done", done, 0);
        @(negedge clk);
        check("idle_ignores_beats", busy, 0);
        check("clear_no_done", done, 0);
        in_valid = 1'b0;

        // start and clear together in IDLE
        start = 1'b1;
        clear = 1'b1;
        @(negedge clk);
        start = 1'b0;
        clear = 1'b0;
        check("start_clear_idle", busy, 0);

        // reset during compute
        randomize_operands();
        do_start();
        load(2 * NN);
        repeat (10) @(negedge clk);
        check("mid_compute_busy", busy, 1);
        rst_n = 1'b0;
        #1;
        check("arst_busy", busy, 0);
        check("arst_in_ready", in_ready, 0);
        check("arst_out_valid", out_valid, 0);
        check("arst_out_data", out_data, 0);
        check("arst_done", done, 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("post_rst_idle", busy, 0);

        randomize_operands();
        run_job(1'b1, 1'b0);
        randomize_operands();
        run_job(1'b0, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end
endmodule

// File: doc/matmul_engine.md
MATMUL_ENGINE -- requirements
Module: matmul_engine

Interface
REQ-001 Parameter N, default 3: matrix dimension; square NxN operands; N >= 2.
REQ-002 Parameter DW, default 4: unsigned operand element width.
REQ-003 Parameter OW, default 10: result element width; OW >= 2*DW + ceil(log2(N)) unless saturation is compiled in (REQ-030).
REQ-004 clk  input  1  single clock; all state on rising edge.
REQ-005 rst_n  input  1  reset, asynchronous, active-low.
REQ-006 start  input  1  begin a load/compute/unload job; sampled only in IDLE.
REQ-007 clear  input  1  synchronous abort to IDLE.
REQ-008 in_valid  input  1  operand beat valid.
REQ-009 in_ready  output  1  operand beat accepted when in_valid && in_ready.
REQ-010 in_data  input  DW  operand element.
REQ-011 out_valid  output  1  result beat valid.
REQ-012 out_ready  input  1  result beat consumed when out_valid && out_ready.
REQ-013 out_data  output  OW  result element.
REQ-014 busy  output  1  high in every state except IDLE.
REQ-015 done  output  1  one-cycle pulse after final result beat consumed.

Function
REQ-016 FSM states IDLE, LOAD, COMPUTE, UNLOAD; IDLE->LOAD on start; LOAD->COMPUTE after 2*N*N accepted beats; COMPUTE->UNLOAD after exactly N*N*N cycles; UNLOAD->IDLE after N*N consumed beats.
REQ-017 LOAD order: first N*N beats are W row-major (W[0][0], W[0][1], ...), next N*N beats are X row-major.
REQ-018 in_ready high only in LOAD; beats offered outside LOAD are ignored.
REQ-019 COMPUTE: one unsigned MAC per cycle; for each (i,j) row-major, accumulate W[i][k]*X[k][j] for k=0..N-1; accumulator cleared at k=0 of each element; R[i][j] written into result buffer on k=N-1.
REQ-020 Products and accumulator unsigned, computed at full width 2*DW+ceil(log2(N)) before reduction to OW.
REQ-021 UNLOAD: R emitted row-major; out_valid asserted first cycle in UNLOAD; out_data stable while out_valid && !out_ready.
REQ-022 done pulses the cycle after the N*N-th result handshake, coincident with return to IDLE.
REQ-023 start while busy is ignored; start and clear in same IDLE cycle: clear wins, stay IDLE.
REQ-024 clear in any state: next cycle IDLE, counters zeroed, out_valid and in_ready low, no done pulse; operand and result buffers not required to be zeroed.
REQ-025 A new job needs a fresh start; buffers from a prior job never leak into a new result.

Reset
REQ-026 rst_n low asynchronously forces IDLE, all counters and accumulator to 0.
REQ-027 During and after reset: in_ready=0, out_valid=0, out_data=0, busy=0, done=0.
REQ-028 Reset mid-job discards the job; first post-reset activity requires start.

Configuration
REQ-029 Macro MATMUL_SAT_EN selects overflow handling on reduction to OW.
REQ-030 Defined: result clamps to 2^OW-1 when full-width sum exceeds it; OW may be below 2*DW+ceil(log2(N)).
REQ-031 Undefined: result is full-width sum modulo 2^OW (low OW bits).

Verification
REQ-032 N=3,DW=4,OW=10: W=identity, X=1..9 row-major -> out_data 1..9 in order, done one cycle after ninth beat.
REQ-033 All 18 operands=15 -> every out_data=675; COMPUTE lasts exactly 27 cycles.
REQ-034 out_ready toggled 1,0,0,1 repeatedly -> out_data held during stalls, 9 beats, no loss or duplication.
REQ-035 start pulsed during COMPUTE and clear asserted in LOAD after 5 beats -> start ignored; clear gives IDLE next cycle, busy=0, no done.
REQ-036 rst_n low mid-COMPUTE -> outputs zero immediately; new job with start yields correct results.
REQ-037 OW=8, all operands 15: with MATMUL_SAT_EN out_data=255; without, out_data=163.
